// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, downstream hold,
// flush-driven bubble insertion and a saturating load-use bubble counter.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               idValid,
  input  logic [XLEN-1:0]    idPc,
  input  logic [XLEN-1:0]    idImm,
  input  logic [4:0]         rs1Addr,
  input  logic [4:0]         rs2Addr,
  input  logic [XLEN-1:0]    rs1Data,
  input  logic [XLEN-1:0]    rs2Data,
  input  logic               idUsesRs1,
  input  logic               idUsesRs2,
  input  logic [4:0]         idRd,
  input  logic               idRegWrite,
  input  logic               idMemRead,
  input  logic               idMemWrite,
  input  logic               idAluSrc,
  input  logic [ALUOP_W-1:0] idAluOp,
  input  logic               exHold,
  input  logic               flush,
  output logic               exValid,
  output logic [XLEN-1:0]    exPc,
  output logic [XLEN-1:0]    exImm,
  output logic [XLEN-1:0]    exRs1Data,
  output logic [XLEN-1:0]    exRs2Data,
  output logic [4:0]         exRs1Addr,
  output logic [4:0]         exRs2Addr,
  output logic [4:0]         exRd,
  output logic               exRegWrite,
  output logic               exMemRead,
  output logic               exMemWrite,
  output logic               exAluSrc,
  output logic [ALUOP_W-1:0] exAluOp,
  output logic               stallOut,
  output logic [CNT_W-1:0]   bubbleCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_imm;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [4:0]         r_rs1_addr;
  logic [4:0]         r_rs2_addr;
  logic [4:0]         r_rd;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_alu_src;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_lu_bubble;

  // A valid load in EX whose non-x0 destination feeds a used source in ID.
  always_comb begin
    w_load_use = r_valid & r_mem_read & (r_rd != 5'd0) & idValid &
                 ((idUsesRs1 & (rs1Addr == r_rd)) | (idUsesRs2 & (rs2Addr == r_rd)));
    w_lu_bubble = ~flush & ~exHold & w_load_use;
    w_bubble    = flush | w_lu_bubble;
    stallOut    = exHold | (w_load_use & ~flush);
  end

  // EX register: flush/load-use bubble, else hold, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= {XLEN{1'b0}};
      r_imm       <= {XLEN{1'b0}};
      r_rs1_data  <= {XLEN{1'b0}};
      r_rs2_data  <= {XLEN{1'b0}};
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= {ALUOP_W{1'b0}};
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= {XLEN{1'b0}};
      r_imm       <= {XLEN{1'b0}};
      r_rs1_data  <= {XLEN{1'b0}};
      r_rs2_data  <= {XLEN{1'b0}};
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= {ALUOP_W{1'b0}};
    end else if (!exHold) begin
      r_valid     <= idValid;
      r_pc        <= idPc;
      r_imm       <= idImm;
      r_rs1_data  <= rs1Data;
      r_rs2_data  <= rs2Data;
      r_rs1_addr  <= rs1Addr;
      r_rs2_addr  <= rs2Addr;
      r_rd        <= idRd;
      r_reg_write <= idRegWrite & idValid;
      r_mem_read  <= idMemRead & idValid;
      r_mem_write <= idMemWrite & idValid;
      r_alu_src   <= idAluSrc;
      r_alu_op    <= idAluOp;
    end
  end

  // Saturating count of load-use bubbles only (flush bubbles are not counted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_lu_bubble && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign exValid     = r_valid;
  assign exPc        = r_pc;
  assign exImm       = r_imm;
  assign exRs1Data   = r_rs1_data;
  assign exRs2Data   = r_rs2_data;
  assign exRs1Addr   = r_rs1_addr;
  assign exRs2Addr   = r_rs2_addr;
  assign exRd        = r_rd;
  assign exRegWrite  = r_reg_write;
  assign exMemRead   = r_mem_read;
  assign exMemWrite  = r_mem_write;
  assign exAluSrc    = r_alu_src;
  assign exAluOp     = r_alu_op;
  assign bubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; CNT_W=2 so counter saturation is reachable.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst_n;
  logic               idValid;
  logic [XLEN-1:0]    idPc, idImm, rs1Data, rs2Data;
  logic [4:0]         rs1Addr, rs2Addr, idRd;
  logic               idUsesRs1, idUsesRs2;
  logic               idRegWrite, idMemRead, idMemWrite, idAluSrc;
  logic [ALUOP_W-1:0] idAluOp;
  logic               exHold, flush;
  logic               exValid;
  logic [XLEN-1:0]    exPc, exImm, exRs1Data, exRs2Data;
  logic [4:0]         exRs1Addr, exRs2Addr, exRd;
  logic               exRegWrite, exMemRead, exMemWrite, exAluSrc;
  logic [ALUOP_W-1:0] exAluOp;
  logic               stallOut;
  logic [CNT_W-1:0]   bubbleCount;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idPc(idPc), .idImm(idImm),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
    .idAluSrc(idAluSrc), .idAluOp(idAluOp), .exHold(exHold), .flush(flush),
    .exValid(exValid), .exPc(exPc), .exImm(exImm), .exRs1Data(exRs1Data),
    .exRs2Data(exRs2Data), .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr),
    .exRd(exRd), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exAluSrc(exAluSrc), .exAluOp(exAluOp),
    .stallOut(stallOut), .bubbleCount(bubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; idValid = 1'b0; idPc = 32'h0; idImm = 32'h0;
    rs1Addr = 5'd0; rs2Addr = 5'd0; rs1Data = 32'h0; rs2Data = 32'h0;
    idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idRd = 5'd0; idRegWrite = 1'b0;
    idMemRead = 1'b0; idMemWrite = 1'b0; idAluSrc = 1'b0; idAluOp = 4'd0;
    exHold = 1'b0; flush = 1'b0;

    // Reset state
    #3;
    chk("rst_exValid", {31'd0, exValid}, 32'd0);
    chk("rst_bubbleCount", {30'd0, bubbleCount}, 32'd0);
    chk("rst_stall_nohold", {31'd0, stallOut}, 32'd0);
    exHold = 1'b1; #1;
    chk("rst_stall_hold", {31'd0, stallOut}, 32'd1);
    exHold = 1'b0;
    #4; rst_n = 1'b1;

    // Normal capture
    idValid = 1'b1; idPc = 32'h100; rs1Data = 32'h11; rs2Data = 32'h22;
    idImm = 32'hFFFF_FFF0; idAluOp = 4'd3; rs1Addr = 5'd1; rs2Addr = 5'd2;
    idRd = 5'd3; idRegWrite = 1'b1; idUsesRs1 = 1'b1; idUsesRs2 = 1'b1; idAluSrc = 1'b1;
    #1;
    chk("cap_stall", {31'd0, stallOut}, 32'd0);
    tick();
    chk("cap_exValid", {31'd0, exValid}, 32'd1);
    chk("cap_exPc", exPc, 32'h100);
    chk("cap_exRs1Data", exRs1Data, 32'h11);
    chk("cap_exRs2Data", exRs2Data, 32'h22);
    chk("cap_exImm", exImm, 32'hFFFF_FFF0);
    chk("cap_exAluOp", {28'd0, exAluOp}, 32'd3);
    chk("cap_exRd", {27'd0, exRd}, 32'd3);
    chk("cap_exRegWrite", {31'd0, exRegWrite}, 32'd1);
    chk("cap_exAluSrc", {31'd0, exAluSrc}, 32'd1);

    // Asynchronous reset mid-cycle with exValid=1
    rst_n = 1'b0; #1;
    chk("arst_exValid", {31'd0, exValid}, 32'd0);
    chk("arst_exPc", exPc, 32'h0);
    chk("arst_exRegWrite", {31'd0, exRegWrite}, 32'd0);
    chk("arst_exImm", exImm, 32'h0);
    rst_n = 1'b1;

    // First edge after release captures; idValid=0 masks write/mem controls
    idValid = 1'b0; idMemWrite = 1'b1;
    tick();
    chk("inv_exValid", {31'd0, exValid}, 32'd0);
    chk("inv_exRegWrite", {31'd0, exRegWrite}, 32'd0);
    chk("inv_exMemWrite", {31'd0, exMemWrite}, 32'd0);
    chk("inv_exPc", exPc, 32'h100);

    // Load-use: load rd=5, then dependent on rs2=5
    idValid = 1'b1; idMemWrite = 1'b0; idMemRead = 1'b1; idRd = 5'd5;
    idPc = 32'h200; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
    tick();
    chk("lu_load_exMemRead", {31'd0, exMemRead}, 32'd1);
    chk("lu_load_exRd", {27'd0, exRd}, 32'd5);
    idMemRead = 1'b0; idPc = 32'h204; idUsesRs2 = 1'b1; rs2Addr = 5'd5;
    rs1Addr = 5'd0; idRd = 5'd6;
    #1;
    chk("lu_stall", {31'd0, stallOut}, 32'd1);
    tick();
    chk("lu_bub_exValid", {31'd0, exValid}, 32'd0);
    chk("lu_bub_exMemRead", {31'd0, exMemRead}, 32'd0);
    chk("lu_bub_exPc", exPc, 32'h0);
    chk("lu_bub_count", {30'd0, bubbleCount}, 32'd1);
    chk("lu_bub_stall", {31'd0, stallOut}, 32'd0);
    tick();
    chk("lu_cap_exValid", {31'd0, exValid}, 32'd1);
    chk("lu_cap_exRs2Addr", {27'd0, exRs2Addr}, 32'd5);
    chk("lu_cap_exPc", exPc, 32'h204);

    // No false hazard: load to x0
    idMemRead = 1'b1; idRd = 5'd0; idPc = 32'h300; idUsesRs2 = 1'b0;
    tick();
    idMemRead = 1'b0; idPc = 32'h304; idUsesRs1 = 1'b1; rs1Addr = 5'd0; idRd = 5'd6;
    #1;
    chk("x0_stall", {31'd0, stallOut}, 32'd0);
    tick();
    chk("x0_exValid", {31'd0, exValid}, 32'd1);
    chk("x0_exPc", exPc, 32'h304);
    chk("x0_count", {30'd0, bubbleCount}, 32'd1);

    // No false hazard: rs1 matches but is unused
    idMemRead = 1'b1; idRd = 5'd7; idPc = 32'h400; idUsesRs1 = 1'b0;
    tick();
    idMemRead = 1'b0; idPc = 32'h404; rs1Addr = 5'd7; idUsesRs1 = 1'b0;
    idUsesRs2 = 1'b1; rs2Addr = 5'd8; idRd = 5'd6;
    #1;
    chk("unused_stall", {31'd0, stallOut}, 32'd0);
    tick();
    chk("unused_exPc", exPc, 32'h404);
    chk("unused_count", {30'd0, bubbleCount}, 32'd1);

    // Hold with a pending load-use, then flush+hold+loadUse together
    idMemRead = 1'b1; idRd = 5'd9; idPc = 32'h500;
    tick();
    idMemRead = 1'b0; idPc = 32'h504; rs1Addr = 5'd9; idUsesRs1 = 1'b1; idRd = 5'd6;
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", {31'd0, stallOut}, 32'd1);
      tick();
      chk("hold_exPc", exPc, 32'h500);
      chk("hold_exRd", {27'd0, exRd}, 32'd9);
      chk("hold_exValid", {31'd0, exValid}, 32'd1);
      chk("hold_count", {30'd0, bubbleCount}, 32'd1);
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stallOut}, 32'd1);
    tick();
    chk("flush_exValid", {31'd0, exValid}, 32'd0);
    chk("flush_exRegWrite", {31'd0, exRegWrite}, 32'd0);
    chk("flush_exPc", exPc, 32'h0);
    chk("flush_count", {30'd0, bubbleCount}, 32'd1);
    flush = 1'b0; exHold = 1'b0;

    // Saturation: reset, then a self-dependent load repeats capture/bubble
    rst_n = 1'b0; #2; rst_n = 1'b1;
    chk("sat_rst_count", {30'd0, bubbleCount}, 32'd0);
    idMemRead = 1'b1; idRd = 5'd5; rs1Addr = 5'd5; idUsesRs1 = 1'b1; idPc = 32'h600;
    tick();
    chk("sat_cap_exMemRead", {31'd0, exMemRead}, 32'd1);
    tick();
    chk("sat_count1", {30'd0, bubbleCount}, 32'd1);
    tick(); tick();
    chk("sat_count2", {30'd0, bubbleCount}, 32'd2);
    tick(); tick();
    chk("sat_count3", {30'd0, bubbleCount}, 32'd3);
    tick(); tick();
    chk("sat_count4", {30'd0, bubbleCount}, 32'd3);
    chk("sat_exValid", {31'd0, exValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
